// File: rtl/load_store_unit.sv
// load_store_unit: serialises one load or store at a time into 8-byte-aligned
// doubleword beats. Loads are sign/zero extended. Sub-doubleword stores use
// read-modify-write. Accesses that straddle a doubleword take two beats each way.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] Mem_Addr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] Write_Data,
    input  logic [63:0] Read_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_buf0;
    logic [63:0] r_buf1;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic [3:0]  w_reqSize;
    logic [64:0] w_reqEnd;
    logic        w_fault;

    logic [3:0]  w_size;
    logic [2:0]  w_off;
    logic [63:0] w_base;
    logic        w_split;

    logic [127:0] w_rdLine;
    logic [63:0]  w_shift;
    logic [63:0]  w_loadVal;
    logic [127:0] w_mask;
    logic [127:0] w_wrData;
    logic [127:0] w_merged;

    // Decode of the incoming request: size and the three fault conditions.
    // The end address is formed one bit wider so a huge address cannot wrap.
    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_reqSize = 4'd1 << req_funct3[1:0];
    assign w_reqEnd  = {1'b0, req_addr} + {61'd0, w_reqSize} - 65'd1;
    assign w_fault   = (w_reqEnd >= 65'(MEM_BYTES))
                     || (req_write && req_funct3[2])
                     || (req_funct3 == 3'b111);

    // Geometry of the latched access.
    assign w_size  = 4'd1 << r_funct3[1:0];
    assign w_off   = r_addr[2:0];
    assign w_base  = {r_addr[63:3], 3'b000};
    assign w_split = ({1'b0, w_off} + w_size) > 4'd8;

    // Line used for the load result; the final read beat is taken straight from
    // Read_Data because its buffer only updates on the same edge that enters RESP.
    always_comb begin
        w_rdLine = {r_buf1, r_buf0};
        if (r_state == S_RD0) begin
            w_rdLine = {64'd0, Read_Data};
        end else if (r_state == S_RD1) begin
            w_rdLine = {Read_Data, r_buf0};
        end
    end

    assign w_shift = 64'(w_rdLine >> {w_off, 3'b000});

    // Keep the low size bytes and extend; funct3[2] selects zero extension.
    always_comb begin
        w_loadVal = w_shift;
        case (r_funct3[1:0])
            2'd0:    w_loadVal = {{56{~r_funct3[2] & w_shift[7]}},  w_shift[7:0]};
            2'd1:    w_loadVal = {{48{~r_funct3[2] & w_shift[15]}}, w_shift[15:0]};
            2'd2:    w_loadVal = {{32{~r_funct3[2] & w_shift[31]}}, w_shift[31:0]};
            default: w_loadVal = w_shift;
        endcase
    end

    // Store merge over the 128-bit line: only the addressed bytes change.
    assign w_mask   = ((128'd1 << {w_size, 3'b000}) - 128'd1) << {w_off, 3'b000};
    assign w_wrData = {64'd0, r_wdata} << {w_off, 3'b000};
    assign w_merged = ({r_buf1, r_buf0} & ~w_mask) | (w_wrData & w_mask);

    // Next-state and memory-port outputs; the port idles at zero outside beats.
    always_comb begin
        w_next     = r_state;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Mem_Addr   = 64'd0;
        Write_Data = 64'd0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_fault ? S_RESP : S_RD0;
                end
            end
            S_RD0: begin
                MemRead  = 1'b1;
                Mem_Addr = w_base;
                if (w_split) begin
                    w_next = S_RD1;
                end else if (r_write) begin
                    w_next = S_WR0;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_RD1: begin
                MemRead  = 1'b1;
                Mem_Addr = w_base + 64'd8;
                w_next   = r_write ? S_WR0 : S_RESP;
            end
            S_WR0: begin
                MemWrite   = 1'b1;
                Mem_Addr   = w_base;
                Write_Data = w_merged[63:0];
                w_next     = w_split ? S_WR1 : S_RESP;
            end
            S_WR1: begin
                MemWrite   = 1'b1;
                Mem_Addr   = w_base + 64'd8;
                Write_Data = w_merged[127:64];
                w_next     = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, request latch, read buffers and registered response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 64'd0;
            r_wdata  <= 64'd0;
            r_buf0   <= 64'd0;
            r_buf1   <= 64'd0;
            r_rdata  <= 64'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_buf0   <= 64'd0;
                r_buf1   <= 64'd0;
            end
            if (r_state == S_RD0) begin
                r_buf0 <= Read_Data;
            end
            if (r_state == S_RD1) begin
                r_buf1 <= Read_Data;
            end
            if (((r_state == S_RD0) || (r_state == S_RD1)) && (w_next == S_RESP)) begin
                r_rdata <= w_loadVal;
            end else begin
                r_rdata <= 64'd0;
            end
            r_err <= (r_state == S_IDLE) && (w_next == S_RESP);
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
